pipe_hazard_ctrl: RTL

//  Central stall/flush scheduler for the 5-stage MIPS pipeline (F/D/E/M/W).

---
 rtl/mips_pipe_pkg.sv | 11 +
 rtl/pipe_hazard_ctrl_div_seq.sv | 48 ++++
 rtl/pipe_hazard_ctrl.sv | 68 ++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared types and constants for the pipeline hazard controller
package mips_pipe_pkg;
  typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_DONE} div_state_t;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;
  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_E = 2;
  localparam int STG_M = 3;
  localparam int STG_W = 4;
  localparam int NUM_STG = 5;
endpackage

// File: rtl/pipe_hazard_ctrl_div_seq.sv
// div_seq: divider sequencing FSM with fixed-latency countdown
module div_seq import mips_pipe_pkg::*; #(
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic hold,
  output logic busy,
  output logic done
);
  localparam int CW = $clog2(DIV_LAT);
  localparam logic [CW-1:0] CNT_INIT = CW'(DIV_LAT - 1);
  div_state_t r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  // state and countdown register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt <= w_cnt_nx;
    end
  end
  // abort wins; the countdown runs regardless of stalls, only the result phase waits for them
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx = r_cnt;
    if (abort) begin
      w_state_nx = IDLE;
      w_cnt_nx = '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          w_state_nx = DIV_RUN;
          w_cnt_nx = CNT_INIT;
        end
        DIV_RUN: if (r_cnt == '0) w_state_nx = DIV_DONE; else w_cnt_nx = r_cnt - CW'(1);
        DIV_DONE: w_state_nx = hold ? DIV_DONE : IDLE;
        default: w_state_nx = IDLE;
      endcase
    end
  end
  assign busy = r_state == DIV_RUN;
  assign done = r_state == DIV_DONE;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: prioritized stall/flush/redirect scheduler for the 5-stage pipeline
module pipe_hazard_ctrl import mips_pipe_pkg::*; #(
  parameter int DIV_LAT = 32,
  parameter logic [31:0] EXC_VECTOR = mips_pipe_pkg::EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_useD,
  input  logic        div_reqE,
  input  logic        inst_busy,
  input  logic        data_busy,
  input  logic        branchM,
  input  logic        pred_takeM,
  input  logic        actual_takeM,
  input  logic [31:0] pc_branchM,
  input  logic [31:0] pcM,
  input  logic        excM,
  output logic        div_start,
  output logic        div_validE,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        stallM,
  output logic        stallW,
  output logic        flushD,
  output logic        flushE,
  output logic        flushM,
  output logic        flushW,
  output logic        pc_redirect,
  output logic [31:0] pc_target
);
  logic r_exc_pend;
  logic w_busy, w_done, w_mem, w_exc, w_sram, w_low, w_run, w_mis, w_lu;
  // an exception seen during a data access waits for that access to finish
  always_ff @(posedge clk) begin
    if (rst) r_exc_pend <= 1'b0;
    else r_exc_pend <= data_busy & (r_exc_pend | excM);
  end
  assign w_mem = inst_busy | data_busy;
  assign w_exc = ~rst & (excM | r_exc_pend) & ~data_busy;
  assign w_sram = ~rst & ~w_exc & w_mem;
  assign w_low = ~rst & ~w_exc & ~w_sram;
  assign w_run = w_low & w_busy;
  assign w_mis = w_low & ~w_busy & branchM & (pred_takeM ^ actual_takeM);
  assign w_lu = w_low & ~w_busy & ~w_mis & load_useD;
  div_seq #(.DIV_LAT(DIV_LAT)) u_div_seq (
    .clk(clk),
    .rst(rst),
    .start(div_start),
    .abort(w_exc),
    .hold(w_mem),
    .busy(w_busy),
    .done(w_done)
  );
  assign div_start = w_low & ~w_busy & ~w_done & div_reqE;
  assign div_validE = ~rst & w_done;
  assign stallF = w_sram | w_run | w_lu;
  assign stallD = w_sram | w_run | w_lu;
  assign stallE = w_sram | w_run;
  assign stallM = w_sram;
  assign stallW = w_sram;
  assign flushD = w_exc | w_mis;
  assign flushE = w_exc | w_lu;
  assign flushM = w_exc | w_run;
  assign flushW = w_exc;
  assign pc_redirect = w_exc | w_mis;
  assign pc_target = w_exc ? EXC_VECTOR : w_mis ? (actual_takeM ? pc_branchM : pcM + 32'd8) : '0;
endmodule
